// File: rtl/cam_lookup_pipe.sv
// Clocked CAM with per-entry valid bits: write/delete/insert/lookup, one op per cycle,
// responses (first-match index, hit, match count) returned through a two-stage pipeline.
`timescale 1ns/1ps
module cam_lookup_pipe #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 8,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              op_valid,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] op_data,
  input  logic [AW-1:0]     op_addr,
  output logic              rsp_valid,
  output logic [1:0]        rsp_op,
  output logic              rsp_hit,
  output logic [AW-1:0]     rsp_addr,
  output logic [CW-1:0]     rsp_count,
  output logic [CW-1:0]     used,
  output logic              full,
  output logic              empty
);

  typedef enum logic [1:0] {
    OP_DELETE = 2'd0,
    OP_WRITE  = 2'd1,
    OP_INSERT = 2'd2,
    OP_LOOKUP = 2'd3
  } op_e;

  logic [DATA_W-1:0] r_key [DEPTH];
  logic [DEPTH-1:0]  r_vld;
  logic [CW-1:0]     r_used;
  logic              r_full;
  logic              r_empty;

  logic              r_s1_valid;
  logic [1:0]        r_s1_op;
  logic [DEPTH-1:0]  r_s1_match;
  logic              r_s1_hit;
  logic [AW-1:0]     r_s1_addr;

  logic              r_rsp_valid;
  logic [1:0]        r_rsp_op;
  logic              r_rsp_hit;
  logic [AW-1:0]     r_rsp_addr;
  logic [CW-1:0]     r_rsp_count;

  logic [DEPTH-1:0]  w_match;
  logic              w_free_ok;
  logic [AW-1:0]     w_free_idx;
  logic [CW-1:0]     w_used_nxt;
  logic              w_s1_hit;
  logic [AW-1:0]     w_s1_addr;
  logic [AW-1:0]     w_pe_idx;
  logic [CW-1:0]     w_pop;

  // Match vector and lowest free slot, both from current storage state
  always_comb begin
    w_match    = '0;
    w_free_ok  = 1'b0;
    w_free_idx = '0;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      w_match[i] = r_vld[i] && (r_key[i] == op_data);
      if (!r_vld[i]) begin
        w_free_ok  = 1'b1;
        w_free_idx = AW'(i);
      end
    end
  end

  always_comb begin
    w_used_nxt = r_used;
    w_s1_hit   = 1'b0;
    w_s1_addr  = '0;
    case (op)
      OP_WRITE: begin
        w_s1_hit  = 1'b1;
        w_s1_addr = op_addr;
        if (op_valid && !r_vld[op_addr]) w_used_nxt = r_used + CW'(1);
      end
      OP_DELETE: begin
        w_s1_hit  = 1'b1;
        w_s1_addr = op_addr;
        if (op_valid && r_vld[op_addr]) w_used_nxt = r_used - CW'(1);
      end
      OP_INSERT: begin
        w_s1_hit  = w_free_ok;
        w_s1_addr = w_free_idx;
        if (op_valid && w_free_ok) w_used_nxt = r_used + CW'(1);
      end
      default: ;
    endcase
  end

  // Storage and occupancy; flags follow the next used value so they never lag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) r_key[i] <= '0;
      r_vld   <= '0;
      r_used  <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      if (op_valid) begin
        case (op)
          OP_WRITE: begin
            r_key[op_addr] <= op_data;
            r_vld[op_addr] <= 1'b1;
          end
          OP_DELETE: r_vld[op_addr] <= 1'b0;
          OP_INSERT: begin
            if (w_free_ok) begin
              r_key[w_free_idx] <= op_data;
              r_vld[w_free_idx] <= 1'b1;
            end
          end
          default: ;
        endcase
      end
      r_used  <= w_used_nxt;
      r_full  <= (w_used_nxt == CW'(DEPTH));
      r_empty <= (w_used_nxt == '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_op    <= '0;
      r_s1_match <= '0;
      r_s1_hit   <= 1'b0;
      r_s1_addr  <= '0;
    end else begin
      r_s1_valid <= op_valid;
      if (op_valid) begin
        r_s1_op    <= op;
        r_s1_match <= (op == OP_LOOKUP) ? w_match : '0;
        r_s1_hit   <= w_s1_hit;
        r_s1_addr  <= w_s1_addr;
      end
    end
  end

  // Priority encode (lowest index) and population count of the staged match vector
  always_comb begin
    w_pe_idx = '0;
    w_pop    = '0;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      if (r_s1_match[i]) w_pe_idx = AW'(i);
      w_pop = w_pop + CW'(r_s1_match[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_op    <= '0;
      r_rsp_hit   <= 1'b0;
      r_rsp_addr  <= '0;
      r_rsp_count <= '0;
    end else begin
      r_rsp_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_rsp_op <= r_s1_op;
        if (r_s1_op == OP_LOOKUP) begin
          r_rsp_hit   <= |r_s1_match;
          r_rsp_addr  <= w_pe_idx;
          r_rsp_count <= w_pop;
        end else begin
          r_rsp_hit   <= r_s1_hit;
          r_rsp_addr  <= r_s1_addr;
          r_rsp_count <= '0;
        end
      end
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_op    = r_rsp_op;
  assign rsp_hit   = r_rsp_hit;
  assign rsp_addr  = r_rsp_addr;
  assign rsp_count = r_rsp_count;
  assign used      = r_used;
  assign full      = r_full;
  assign empty     = r_empty;

endmodule

// File: tb/tb_cam_lookup_pipe.sv
// Directed bench for cam_lookup_pipe: hand-computed responses queued with their due cycle
// and checked by a monitor; occupancy and reset values checked inline.
`timescale 1ns/1ps
module tb_cam_lookup_pipe;

  logic        clk      = 1'b0;
  logic        rst      = 1'b0;
  logic        op_valid = 1'b0;
  logic [1:0]  op       = 2'd0;
  logic [15:0] op_data  = 16'd0;
  logic [2:0]  op_addr  = 3'd0;
  logic        rsp_valid;
  logic [1:0]  rsp_op;
  logic        rsp_hit;
  logic [2:0]  rsp_addr;
  logic [3:0]  rsp_count;
  logic [3:0]  used;
  logic        full;
  logic        empty;

  cam_lookup_pipe #(.DATA_W(16), .DEPTH(8)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op(op), .op_data(op_data),
    .op_addr(op_addr), .rsp_valid(rsp_valid), .rsp_op(rsp_op), .rsp_hit(rsp_hit),
    .rsp_addr(rsp_addr), .rsp_count(rsp_count), .used(used), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         due;
    logic [1:0] op;
    logic       hit;
    logic [2:0] addr;
    logic [3:0] cnt;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Samples 1ns after each rising edge; a response is due two cycles after its issue
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (q.size() > 0 && q[0].due < cyc) begin
        check_val("rsp_missed", 32'(q[0].due), 32'(cyc));
        void'(q.pop_front());
      end
      if (q.size() > 0 && q[0].due == cyc) begin
        check_val($sformatf("rsp_valid@%0d", cyc), 32'(rsp_valid), 32'd1);
        check_val($sformatf("rsp_op@%0d", cyc),    32'(rsp_op),    32'(q[0].op));
        check_val($sformatf("rsp_hit@%0d", cyc),   32'(rsp_hit),   32'(q[0].hit));
        check_val($sformatf("rsp_addr@%0d", cyc),  32'(rsp_addr),  32'(q[0].addr));
        check_val($sformatf("rsp_count@%0d", cyc), 32'(rsp_count), 32'(q[0].cnt));
        void'(q.pop_front());
      end else begin
        check_val($sformatf("rsp_idle@%0d", cyc), 32'(rsp_valid), 32'd0);
      end
    end
  end

  task automatic push_exp(input logic [1:0] o, input logic eh, input logic [2:0] ea,
                          input logic [3:0] ec);
    exp_t e;
    e.due = cyc + 2; e.op = o; e.hit = eh; e.addr = ea; e.cnt = ec;
    q.push_back(e);
  endtask

  task automatic issue(input logic [1:0] o, input logic [15:0] d, input logic [2:0] a,
                       input logic eh, input logic [2:0] ea, input logic [3:0] ec);
    @(negedge clk);
    op_valid = 1'b1; op = o; op_data = d; op_addr = a;
    push_exp(o, eh, ea, ec);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      op_valid = 1'b0;
    end
  endtask

  task automatic check_occ(input string tag, input logic [3:0] u, input logic f, input logic e);
    check_val({tag, "_used"},  32'(used),  32'(u));
    check_val({tag, "_full"},  32'(full),  32'(f));
    check_val({tag, "_empty"}, 32'(empty), 32'(e));
  endtask

  task automatic check_reset_outs(input string tag);
    check_val({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check_val({tag, "_rsp_op"},    32'(rsp_op),    32'd0);
    check_val({tag, "_rsp_hit"},   32'(rsp_hit),   32'd0);
    check_val({tag, "_rsp_addr"},  32'(rsp_addr),  32'd0);
    check_val({tag, "_rsp_count"}, 32'(rsp_count), 32'd0);
    check_occ(tag, 4'd0, 1'b0, 1'b1);
  endtask

  initial begin
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outs("por");

    // Deassert and present the first LOOKUP in the same cycle: accepted on the first edge
    @(negedge clk);
    rst = 1'b0;
    op_valid = 1'b1; op = 2'd3; op_data = 16'd0; op_addr = 3'd0;
    push_exp(2'd3, 1'b0, 3'd0, 4'd0);
    idle(3);
    check_occ("after_l0", 4'd0, 1'b0, 1'b1);

    for (int i = 0; i < 8; i++) issue(2'd1, 16'(i), 3'(i), 1'b1, 3'(i), 4'd0);
    issue(2'd3, 16'd2, 3'd0, 1'b1, 3'd2, 4'd1);
    idle(3);
    check_occ("filled", 4'd8, 1'b1, 1'b0);

    // Duplicate key and a miss; overwrite of a valid entry leaves used alone
    issue(2'd1, 16'd2, 3'd5, 1'b1, 3'd5, 4'd0);
    issue(2'd3, 16'd2, 3'd0, 1'b1, 3'd2, 4'd2);
    issue(2'd3, 16'd9, 3'd0, 1'b0, 3'd0, 4'd0);
    idle(3);
    check_occ("dup", 4'd8, 1'b1, 1'b0);

    // Deletes, including a repeat delete of an already-invalid entry
    issue(2'd0, 16'd0, 3'd2, 1'b1, 3'd2, 4'd0);
    issue(2'd0, 16'd0, 3'd3, 1'b1, 3'd3, 4'd0);
    issue(2'd0, 16'd0, 3'd2, 1'b1, 3'd2, 4'd0);
    idle(2);
    check_occ("deleted", 4'd6, 1'b0, 1'b0);

    issue(2'd2, 16'd9, 3'd0, 1'b1, 3'd2, 4'd0);
    issue(2'd2, 16'd9, 3'd0, 1'b1, 3'd3, 4'd0);
    issue(2'd3, 16'd9, 3'd0, 1'b1, 3'd2, 4'd2);
    issue(2'd2, 16'd9, 3'd0, 1'b0, 3'd0, 4'd0);
    idle(3);
    check_occ("ins_full", 4'd8, 1'b1, 1'b0);

    // Read-after-write ordering, back-to-back
    issue(2'd1, 16'd7, 3'd0, 1'b1, 3'd0, 4'd0);
    issue(2'd3, 16'd7, 3'd0, 1'b1, 3'd0, 4'd2);
    issue(2'd3, 16'd7, 3'd0, 1'b1, 3'd0, 4'd2);
    issue(2'd1, 16'd7, 3'd1, 1'b1, 3'd1, 4'd0);
    issue(2'd3, 16'd7, 3'd0, 1'b1, 3'd0, 4'd3);

    // Every entry matches: count needs the full CW width
    for (int i = 0; i < 8; i++) issue(2'd1, 16'hABCD, 3'(i), 1'b1, 3'(i), 4'd0);
    issue(2'd3, 16'hABCD, 3'd0, 1'b1, 3'd0, 4'd8);
    idle(3);

    // Reset with lookups in the pipeline: the second one must never respond
    issue(2'd3, 16'hABCD, 3'd0, 1'b1, 3'd0, 4'd8);
    issue(2'd3, 16'hABCD, 3'd0, 1'b1, 3'd0, 4'd8);
    @(negedge clk);
    op_valid = 1'b0;
    rst = 1'b1;
    q.delete();
    repeat (3) @(negedge clk);
    check_reset_outs("mid_rst");
    rst = 1'b0;

    issue(2'd3, 16'hABCD, 3'd0, 1'b0, 3'd0, 4'd0);
    issue(2'd0, 16'd0, 3'd4, 1'b1, 3'd4, 4'd0);
    idle(4);
    check_occ("post_rst", 4'd0, 1'b0, 1'b1);
    check_val("drain", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/cam_lookup_pipe.md
# cam_lookup_pipe

Parametrised, clocked content-addressable memory that stores up to DEPTH keys of DATA_W bits with per-entry valid bits. It supports explicit write, delete, insert-to-free-slot and lookup operations, one per cycle. Lookups return first-match address, hit flag and match count through a fixed two-cycle pipeline. It replaces the earlier combinational 8x16 CAM as the lookup engine in front of table-managed datapaths and adds runtime writes, deletes, free-slot allocation and occupancy tracking.

## Interface
- DATA_W, 16, key width in bits (>=1)
- DEPTH, 8, number of entries; power of two, >=2
- AW (derived), $clog2(DEPTH), address width
- CW (derived), $clog2(DEPTH+1), count width
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- op_valid  input  1  operation request this cycle; always accepted (no backpressure)
- op  input  2  0=DELETE, 1=WRITE, 2=INSERT, 3=LOOKUP
- op_data  input  DATA_W  key for WRITE/INSERT/LOOKUP; ignored for DELETE
- op_addr  input  AW  target entry for WRITE/DELETE; ignored otherwise
- rsp_valid  output  1  one-cycle pulse, response for the op accepted 2 cycles earlier
- rsp_op  output  2  opcode of the responding op
- rsp_hit  output  1  LOOKUP: >=1 match; INSERT: slot allocated; WRITE/DELETE: 1
- rsp_addr  output  AW  LOOKUP: lowest matching index; INSERT: allocated index; WRITE/DELETE: op_addr; 0 on miss/fail
- rsp_count  output  CW  LOOKUP: number of valid matching entries; 0 for other ops
- used  output  CW  number of valid entries (registered)
- full  output  1  used == DEPTH
- empty  output  1  used == 0

## Operation
- Storage: key[DEPTH], vld[DEPTH]. Only valid entries participate in matching.
- Accept cycle N (op_valid=1):
  - WRITE: key[op_addr]<=op_data, vld[op_addr]<=1. Overwriting a valid entry leaves used unchanged; writing an invalid entry increments used.
  - DELETE: vld[op_addr]<=0. Decrements used only if the entry was valid. Key contents are left unchanged.
  - INSERT: selects the lowest index with vld=0 from the state at cycle N. If one exists, writes it as WRITE does and sets hit=1 with that index. If full, no state change, hit=0, addr=0.
  - LOOKUP: match vector = vld & (key==op_data), sampled from the state at cycle N. Storage is unchanged.
- Duplicate keys are permitted. No uniqueness check is made on WRITE or INSERT.
- Pipeline:
  - Stage 1 (edge ending cycle N) registers op, match vector or allocation result, and addr.
  - Stage 2 (edge ending cycle N+1) registers the priority-encoded lowest index and the population count into rsp_*.
- op_valid=0 inserts a bubble. rsp_valid is 0 for the corresponding response cycle. rsp_* data holds its last value.

## Timing
- Latency: an op accepted in cycle N produces rsp_valid=1 in cycle N+2. Throughput is 1 op/cycle with no stalls.
- Storage, used, full and empty update at the edge ending cycle N. They are visible from cycle N+1.
- Read-after-write: an op accepted at N+1 sees the write, delete or insert done at N. A LOOKUP at N is unaffected by a WRITE at N+1.
- The occupancy flags are registered and consistent with used every cycle.
- Reset (async assert, any time including mid-pipeline):
  - all vld=0 and all key=0
  - pipeline valid bits cleared, so in-flight responses are dropped
  - rsp_valid=0, rsp_op=0, rsp_hit=0, rsp_addr=0, rsp_count=0
  - used=0, full=0, empty=1
- The first op is accepted on the first rising edge after rst deasserts.
- Boundaries:
  - INSERT when full: rsp_hit=0 and used stays at DEPTH.
  - DELETE when empty or on an invalid entry: no change, rsp_hit=1.
  - LOOKUP when all keys match: rsp_count=DEPTH (needs CW bits), rsp_addr=0.

## Test plan
- Reset then LOOKUP 0 -> at +2 cycles rsp_valid=1, hit=0, addr=0, count=0. The stored key=0 with vld=0 must not match. empty=1.
- WRITE keys 0..7 (value=index) to addr 0..7, then LOOKUP 2 -> hit=1, addr=2, count=1. full=1, used=8.
- WRITE addr 5 <= 2, then LOOKUP 2 -> hit=1, addr=2, count=2. LOOKUP 9 -> hit=0, count=0.
- DELETE addr 2 and addr 3, then INSERT 9 -> rsp_hit=1, addr=2. Next INSERT 9 -> addr=3. LOOKUP 9 -> addr=2, count=2. Another INSERT -> hit=0, used=8.
- Back-to-back: WRITE addr0<=7 at N, LOOKUP 7 at N+1 -> hit=1, addr=0. LOOKUP 7 at N, then WRITE addr1<=7 at N+1 -> the first response has count excluding addr1.
- Assert rst with two LOOKUPs in flight -> no rsp_valid pulses follow. All outputs are at reset values and a post-reset LOOKUP misses.
